// File: rtl/memory_arbiter_pkg.sv
// Shared types for the fetch/data SRAM arbiter: port identifiers and the
// in-flight read tag carried alongside each SRAM access.
package common;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } mem_port_e;

    typedef struct packed {
        logic      valid;
        mem_port_e port;
    } arb_tag_t;

    // Drops a fetch tag when a flush is in effect; data tags always survive.
    function automatic arb_tag_t flush_scrub(input arb_tag_t tag, input logic flush);
        arb_tag_t result;
        result = tag;
        if (flush && tag.port == PORT_FETCH) begin
            result.valid = 1'b0;
        end
        return result;
    endfunction

endpackage

// File: rtl/memory_arbiter_tag_pipe.sv
// Read-tag delay line matching the SRAM read latency; the tail names the port
// that owns the read data currently on mem_rdata.
module arb_tag_pipe
    import common::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  arb_tag_t push,
    input  logic     flush,
    output arb_tag_t tail
);

    arb_tag_t stages [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= flush_scrub(push, flush);
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= flush_scrub(stages[i-1], flush);
            end
        end
    end

    assign tail = stages[DEPTH-1];

endmodule

// File: rtl/memory_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and the data stage.
// Data wins by default; a streak counter forces a fetch grant after a run of data grants.
module memory_arbiter
    import common::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int READ_LATENCY    = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [ADDR_WIDTH-1:0]   if_req_addr,
    input  logic                    if_flush,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rsp_data,
    input  logic                    dm_req_valid,
    output logic                    dm_req_ready,
    input  logic [ADDR_WIDTH-1:0]   dm_req_addr,
    input  logic                    dm_req_write,
    input  logic [DATA_WIDTH-1:0]   dm_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] dm_req_wstrb,
    output logic                    dm_rsp_valid,
    output logic [DATA_WIDTH-1:0]   dm_rsp_data,
    output logic                    mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_next;
    logic                dm_grant;
    logic                if_grant;
    arb_tag_t            tag_push;
    arb_tag_t            tag_tail;

    // Grants are gated by rst so nothing reaches the SRAM while reset is held.
    always_comb begin
        dm_grant = 1'b0;
        if_grant = 1'b0;
        if (rst) begin
            if (dm_req_valid && !(if_req_valid && streak == STREAK_MAX)) begin
                dm_grant = 1'b1;
            end else if (if_req_valid) begin
                if_grant = 1'b1;
            end
        end
    end

    always_comb begin
        streak_next = streak;
        if (!if_req_valid || if_grant) begin
            streak_next = '0;
        end else if (dm_grant && streak != STREAK_MAX) begin
            streak_next = streak + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= '0;
        end else begin
            streak <= streak_next;
        end
    end

    assign if_req_ready = if_grant;
    assign dm_req_ready = dm_grant;

    assign mem_en    = if_grant | dm_grant;
    assign mem_we    = (dm_grant && dm_req_write) ? dm_req_wstrb : '0;
    assign mem_addr  = dm_grant ? dm_req_addr : if_req_addr;
    assign mem_wdata = dm_req_wdata;

    // Writes push an invalid tag so they never generate a response.
    always_comb begin
        tag_push       = '0;
        tag_push.valid = if_grant | (dm_grant & ~dm_req_write);
        tag_push.port  = dm_grant ? PORT_DATA : PORT_FETCH;
    end

    arb_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_push),
        .flush (if_flush),
        .tail  (tag_tail)
    );

    assign if_rsp_valid = tag_tail.valid && tag_tail.port == PORT_FETCH && !if_flush;
    assign dm_rsp_valid = tag_tail.valid && tag_tail.port == PORT_DATA;
    assign if_rsp_data  = mem_rdata;
    assign dm_rsp_data  = mem_rdata;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: two instances (read latency 1 and 2) share one stimulus;
// a grant/streak model and per-instance response queues check every cycle.
module tb_memory_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_v = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_flush = 1'b0;
    logic        dm_v = 1'b0;
    logic [31:0] dm_addr = '0;
    logic        dm_write = 1'b0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_wstrb = '0;

    logic        if_rdy [2];
    logic        if_rv  [2];
    logic [31:0] if_rd  [2];
    logic        dm_rdy [2];
    logic        dm_rv  [2];
    logic [31:0] dm_rd  [2];
    logic        m_en   [2];
    logic [3:0]  m_we   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata[2];
    logic [31:0] m_rdata[2];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ms = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(1), .MAX_DATA_STREAK(MAXS)) u_dut1 (
        .clk(clk), .rst(rst_n),
        .if_req_valid(if_v), .if_req_ready(if_rdy[0]), .if_req_addr(if_addr), .if_flush(if_flush),
        .if_rsp_valid(if_rv[0]), .if_rsp_data(if_rd[0]),
        .dm_req_valid(dm_v), .dm_req_ready(dm_rdy[0]), .dm_req_addr(dm_addr), .dm_req_write(dm_write),
        .dm_req_wdata(dm_wdata), .dm_req_wstrb(dm_wstrb), .dm_rsp_valid(dm_rv[0]), .dm_rsp_data(dm_rd[0]),
        .mem_en(m_en[0]), .mem_we(m_we[0]), .mem_addr(m_addr[0]), .mem_wdata(m_wdata[0]), .mem_rdata(m_rdata[0])
    );

    memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(2), .MAX_DATA_STREAK(MAXS)) u_dut2 (
        .clk(clk), .rst(rst_n),
        .if_req_valid(if_v), .if_req_ready(if_rdy[1]), .if_req_addr(if_addr), .if_flush(if_flush),
        .if_rsp_valid(if_rv[1]), .if_rsp_data(if_rd[1]),
        .dm_req_valid(dm_v), .dm_req_ready(dm_rdy[1]), .dm_req_addr(dm_addr), .dm_req_write(dm_write),
        .dm_req_wdata(dm_wdata), .dm_req_wstrb(dm_wstrb), .dm_rsp_valid(dm_rv[1]), .dm_rsp_data(dm_rd[1]),
        .mem_en(m_en[1]), .mem_we(m_we[1]), .mem_addr(m_addr[1]), .mem_wdata(m_wdata[1]), .mem_rdata(m_rdata[1])
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0001_0001;
    endfunction

    // SRAM models: latency 1 for u_dut1, latency 2 for u_dut2.
    logic [31:0] sram0 [256];
    logic [31:0] sram1 [256];
    logic [31:0] ref_mem [256];
    logic [31:0] p0 = '0, p1a = '0, p1b = '0;

    assign m_rdata[0] = p0;
    assign m_rdata[1] = p1b;

    always @(posedge clk) begin
        if (m_en[0]) begin
            if (m_we[0] == 4'b0) p0 <= sram0[m_addr[0][9:2]];
            for (int b = 0; b < 4; b++)
                if (m_we[0][b]) sram0[m_addr[0][9:2]][8*b +: 8] <= m_wdata[0][8*b +: 8];
        end
        if (m_en[1]) begin
            if (m_we[1] == 4'b0) p1a <= sram1[m_addr[1][9:2]];
            for (int b = 0; b < 4; b++)
                if (m_we[1][b]) sram1[m_addr[1][9:2]][8*b +: 8] <= m_wdata[1][8*b +: 8];
        end
        p1b <= p1a;
    end

    typedef struct {
        int          due;
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%h want=%h", tag, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        logic        pdm, pif, ev;
        logic [3:0]  pwe;
        exp_t        e;
        exp_t        ne;
        pdm = rst_n && dm_v && !(if_v && ms == MAXS);
        pif = rst_n && if_v && !pdm;
        pwe = (pdm && dm_write) ? dm_wstrb : 4'b0;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end
        if (if_flush) begin
            for (int i = q0.size() - 1; i >= 0; i--) if (q0[i].port == 1'b0) q0.delete(i);
            for (int i = q1.size() - 1; i >= 0; i--) if (q1[i].port == 1'b0) q1.delete(i);
        end
        for (int k = 0; k < 2; k++) begin
            check_val("if_ready", 32'(if_rdy[k]), 32'(pif));
            check_val("dm_ready", 32'(dm_rdy[k]), 32'(pdm));
            check_val("mem_en", 32'(m_en[k]), 32'(pif | pdm));
            check_val("mem_we", 32'(m_we[k]), 32'(pwe));
            if (pif || pdm) check_val("mem_addr", m_addr[k], pdm ? dm_addr : if_addr);
            if (pdm && dm_write) check_val("mem_wdata", m_wdata[k], dm_wdata);
            ev = 1'b0;
            e = '{0, 1'b0, 32'h0};
            if (k == 0) begin
                if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); ev = 1'b1; end
            end else begin
                if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); ev = 1'b1; end
            end
            check_val("if_rsp_valid", 32'(if_rv[k]), 32'(ev && !e.port));
            check_val("dm_rsp_valid", 32'(dm_rv[k]), 32'(ev && e.port));
            if (ev && !e.port) check_val("if_rsp_data", if_rd[k], e.data);
            if (ev && e.port) check_val("dm_rsp_data", dm_rd[k], e.data);
        end
        if (pif && !if_flush) begin
            ne = '{cyc + 1, 1'b0, ref_mem[if_addr[9:2]]};
            q0.push_back(ne);
            ne.due = cyc + 2;
            q1.push_back(ne);
        end
        if (pdm && !dm_write) begin
            ne = '{cyc + 1, 1'b1, ref_mem[dm_addr[9:2]]};
            q0.push_back(ne);
            ne.due = cyc + 2;
            q1.push_back(ne);
        end
        if (pdm && dm_write)
            for (int b = 0; b < 4; b++)
                if (dm_wstrb[b]) ref_mem[dm_addr[9:2]][8*b +: 8] = dm_wdata[8*b +: 8];
        if (!rst_n || !if_v || pif) ms = 0;
        else if (pdm && ms < MAXS) ms++;
    end

    task automatic drive(input logic iv, input logic [31:0] ia, input logic dv, input logic dw,
                         input logic [31:0] da, input logic [31:0] wd, input logic [3:0] ws,
                         input logic fl);
        @(posedge clk);
        #1;
        if_v = iv; if_addr = ia; dm_v = dv; dm_write = dw;
        dm_addr = da; dm_wdata = wd; dm_wstrb = ws; if_flush = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram0[i] = init_word(i);
            sram1[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // consecutive fetch reads
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        idle(3);

        // contention: dm x4 then if, repeating
        for (int i = 0; i < 15; i++)
            drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20 + 32'(4 * (i % 4)), 32'h0, 4'h0, 1'b0);
        idle(3);

        // partial write then read-back, no response for the write
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
        idle(3);

        // flush with fetch reads in flight and a data read that must survive
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive(1'b1, 32'h44, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0);
        drive(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        idle(4);

        // alternating ports back to back
        for (int i = 0; i < 6; i++)
            drive(i % 2 == 0, 32'h30 + 32'(4 * i), i % 2 == 1, 1'b0, 32'h60 + 32'(4 * i), 32'h0, 4'h0, 1'b0);
        idle(3);

        // reset while reads are in flight
        drive(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h60, 32'h0, 4'h0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        if_v = 1'b0; dm_v = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);

        // mixed random traffic
        for (int i = 0; i < 80; i++)
            drive($urandom_range(0, 1) == 1, {22'h0, 8'($urandom_range(0, 255)), 2'b00},
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  {22'h0, 8'($urandom_range(0, 255)), 2'b00}, $urandom,
                  4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
